pong_match_ctrl: RTL and testbench

Match-level sequencer for the Pong datapath. Decides when the ball/paddle update logic may advance each frame, when the ball is re-centred for a serve, and when points are scored. It owns the 8-bit score bus: opponent score in [7:4], player score in [3:0]. It sits between the VGA frame timing (frame_tick) and the ball/paddle datapath inside tt_um_PongGame.

---
 rtl/pong_match_ctrl_if.sv | 25 ++
 rtl/pong_match_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the Pong datapath (master) and the match sequencer (slave).
interface pong_match_ctrl_if;
    logic       frame_tick;
    logic       start_btn;
    logic       miss_player;
    logic       miss_opponent;
    logic       pause_btn;
    logic       ball_reset;
    logic       ball_move_en;
    logic       paddle_move_en;
    logic       serve_dir;
    logic [7:0] score;
    logic       game_over;
    logic [2:0] state;

    modport master (
        output frame_tick, start_btn, miss_player, miss_opponent, pause_btn,
        input  ball_reset, ball_move_en, paddle_move_en, serve_dir, score, game_over, state
    );

    modport slave (
        input  frame_tick, start_btn, miss_player, miss_opponent, pause_btn,
        output ball_reset, ball_move_en, paddle_move_en, serve_dir, score, game_over, state
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve countdown, point scoring and game-over handling.
// Optional pause support is compiled in when PONG_PAUSE_EN is defined.
module pong_match_ctrl #(
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    pong_match_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_e;

    localparam logic [7:0] SERVE_CNT = 8'(SERVE_FRAMES);
    localparam logic [3:0] WIN_NIB   = 4'(WIN_SCORE);

    state_e     state_q, state_d;
    logic [7:0] score_q, score_d;
    logic [7:0] cnt_q, cnt_d;
    logic       start_btn_q, start_btn_d;
    logic       scorer_q, scorer_d;          // 1 = player scored the pending point
    logic       serve_dir_q, serve_dir_d;
    logic       ball_reset_q, ball_reset_d;
    logic       ball_move_en_q, ball_move_en_d;
    logic       paddle_move_en_q, paddle_move_en_d;
    logic       game_over_q, game_over_d;

    logic       start_rise;
    logic       tick;
    logic       miss_p;
    logic       miss_o;
    logic       halted;
    logic [3:0] nib;

`ifdef PONG_PAUSE_EN
    logic       paused_q, paused_d;
    logic       pause_btn_q, pause_btn_d;
    assign halted = paused_q;
`else
    logic       unused_pause_btn;
    assign unused_pause_btn = bus.pause_btn;
    assign halted = 1'b0;
`endif

    assign start_rise = bus.start_btn & ~start_btn_q;
    assign tick       = bus.frame_tick & ~halted;
    assign miss_p     = bus.miss_player & ~halted;
    assign miss_o     = bus.miss_opponent & ~halted;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        cnt_d        = cnt_q;
        scorer_d     = scorer_q;
        serve_dir_d  = serve_dir_q;
        ball_reset_d = 1'b0;
        start_btn_d  = bus.start_btn;
        nib          = 4'd0;

        case (state_q)
            IDLE, GAME_OVER: begin
                if (start_rise) begin
                    state_d      = SERVE;
                    score_d      = 8'h00;
                    cnt_d        = SERVE_CNT;
                    ball_reset_d = 1'b1;
                    serve_dir_d  = 1'b0;
                end
            end
            SERVE: begin
                if (tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) state_d = PLAY;
                end
            end
            PLAY: begin
                if (miss_p && miss_o) begin
                    state_d      = SERVE;
                    cnt_d        = SERVE_CNT;
                    ball_reset_d = 1'b1;
                end else if (miss_p) begin
                    state_d  = POINT;
                    scorer_d = 1'b0;
                end else if (miss_o) begin
                    state_d  = POINT;
                    scorer_d = 1'b1;
                end
            end
            POINT: begin
                if (scorer_q) begin
                    nib          = score_q[3:0] + 4'd1;
                    score_d[3:0] = nib;
                end else begin
                    nib          = score_q[7:4] + 4'd1;
                    score_d[7:4] = nib;
                end
                if (nib == WIN_NIB) begin
                    state_d = GAME_OVER;
                end else begin
                    state_d      = SERVE;
                    cnt_d        = SERVE_CNT;
                    ball_reset_d = 1'b1;
                    serve_dir_d  = scorer_q;   // serve toward the side that conceded
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PONG_PAUSE_EN
    always_comb begin
        pause_btn_d = bus.pause_btn;
        paused_d    = paused_q;
        if ((state_q == SERVE || state_q == PLAY) && bus.pause_btn && !pause_btn_q)
            paused_d = ~paused_q;
        if (state_d != SERVE && state_d != PLAY)
            paused_d = 1'b0;
    end
`endif

    // Enables are derived from the next state so they change on the same edge as state.
    always_comb begin
        paddle_move_en_d = (state_d == SERVE) || (state_d == PLAY);
        ball_move_en_d   = (state_d == PLAY);
        game_over_d      = (state_d == GAME_OVER);
`ifdef PONG_PAUSE_EN
        if (paused_d) begin
            paddle_move_en_d = 1'b0;
            ball_move_en_d   = 1'b0;
        end
`endif
    end

    // NOTE: reset is synchronous, so it only takes effect on a clock edge.
    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            score_q          <= 8'h00;
            cnt_q            <= 8'd0;
            start_btn_q      <= 1'b0;
            scorer_q         <= 1'b0;
            serve_dir_q      <= 1'b0;
            ball_reset_q     <= 1'b0;
            ball_move_en_q   <= 1'b0;
            paddle_move_en_q <= 1'b0;
            game_over_q      <= 1'b0;
`ifdef PONG_PAUSE_EN
            paused_q         <= 1'b0;
            pause_btn_q      <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            score_q          <= score_d;
            cnt_q            <= cnt_d;
            start_btn_q      <= start_btn_d;
            scorer_q         <= scorer_d;
            serve_dir_q      <= serve_dir_d;
            ball_reset_q     <= ball_reset_d;
            ball_move_en_q   <= ball_move_en_d;
            paddle_move_en_q <= paddle_move_en_d;
            game_over_q      <= game_over_d;
`ifdef PONG_PAUSE_EN
            paused_q         <= paused_d;
            pause_btn_q      <= pause_btn_d;
`endif
        end
    end

    assign bus.ball_reset     = ball_reset_q;
    assign bus.ball_move_en   = ball_move_en_q;
    assign bus.paddle_move_en = paddle_move_en_q;
    assign bus.serve_dir      = serve_dir_q;
    assign bus.score          = score_q;
    assign bus.game_over      = game_over_q;
    assign bus.state          = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with SERVE_FRAMES=3, WIN_SCORE=2.
// Pause checks switch with PONG_PAUSE_EN.
module tb_pong_match_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pong_match_ctrl_if bus ();

    pong_match_ctrl #(
        .SERVE_FRAMES (3),
        .WIN_SCORE    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the edge they were updated on.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic miss(input logic p, input logic o);
        bus.miss_player   = p;
        bus.miss_opponent = o;
        step();
        bus.miss_player   = 1'b0;
        bus.miss_opponent = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic [7:0] sc,
                              input logic br, input logic bm, input logic pm, input logic go);
        check({tag, ".state"},  32'(bus.state), 32'(st));
        check({tag, ".score"},  32'(bus.score), 32'(sc));
        check({tag, ".ball_reset"}, 32'(bus.ball_reset), 32'(br));
        check({tag, ".ball_en"},    32'(bus.ball_move_en), 32'(bm));
        check({tag, ".paddle_en"},  32'(bus.paddle_move_en), 32'(pm));
        check({tag, ".game_over"},  32'(bus.game_over), 32'(go));
    endtask

    task automatic serve_to_play();
        tick();
        tick();
        tick();
    endtask

    task automatic press_start();
        bus.start_btn = 1'b0;
        step();
        bus.start_btn = 1'b1;
        step();
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.frame_tick    = 1'b0;
        bus.start_btn     = 1'b0;
        bus.miss_player   = 1'b0;
        bus.miss_opponent = 1'b0;
        bus.pause_btn     = 1'b0;
        step();
        step();
        check_outs("reset", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.serve_dir", 32'(bus.serve_dir), 32'd0);
        rst_n = 1'b1;
        tick();
        miss(1'b1, 1'b0);
        check_outs("idle_ignores", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start and serve countdown
        bus.start_btn = 1'b1;
        step();
        check_outs("start", 3'd1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        check("start.pulse_end", 32'(bus.ball_reset), 32'd0);
        tick();
        miss(1'b0, 1'b1);
        check_outs("serve_ignores_miss", 3'd1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("serve.two_ticks", 32'(bus.state), 32'd1);
        bus.pause_btn = 1'b1;
        step();
        bus.pause_btn = 1'b0;
`ifndef PONG_PAUSE_EN
        check("serve.pause_ignored", 32'(bus.paddle_move_en), 32'd1);
`endif
        step();
`ifdef PONG_PAUSE_EN
        bus.pause_btn = 1'b1;
        step();
        bus.pause_btn = 1'b0;
`endif
        tick();
        check_outs("play", 3'd2, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);

        // Player scores
        miss(1'b0, 1'b1);
        check_outs("point", 3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_outs("p_scored", 3'd1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        check("p_scored.dir", 32'(bus.serve_dir), 32'd1);
        serve_to_play();
        check("p_scored.play", 32'(bus.state), 32'd2);

        // Opponent scores
        miss(1'b1, 1'b0);
        step();
        check_outs("o_scored", 3'd1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
        check("o_scored.dir", 32'(bus.serve_dir), 32'd0);
        serve_to_play();

        // Player reaches WIN_SCORE while start_btn is still held high
        miss(1'b0, 1'b1);
        step();
        check_outs("p_wins", 3'd4, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        miss(1'b1, 1'b0);
        miss(1'b0, 1'b1);
        step();
        check_outs("over_hold", 3'd4, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1);

        press_start();
        check_outs("restart", 3'd1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        check("restart.dir", 32'(bus.serve_dir), 32'd0);
        serve_to_play();
        miss(1'b0, 1'b1);
        step();
        check("m2.score", 32'(bus.score), 32'h01);
        serve_to_play();

        // Simultaneous misses: no score, immediate re-serve, direction kept
        miss(1'b1, 1'b1);
        check_outs("both_miss", 3'd1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        check("both_miss.dir", 32'(bus.serve_dir), 32'd1);
        step();
        check("both_miss.pulse_end", 32'(bus.ball_reset), 32'd0);
        serve_to_play();

        // Opponent reaches WIN_SCORE
        miss(1'b1, 1'b0);
        step();
        check("o1.score", 32'(bus.score), 32'h11);
        serve_to_play();
        miss(1'b1, 1'b0);
        step();
        check_outs("o_wins", 3'd4, 8'h21, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a serve countdown
        press_start();
        tick();
        rst_n = 1'b0;
        step();
        check_outs("mid_reset", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

`ifdef PONG_PAUSE_EN
        press_start();
        tick();
        bus.pause_btn = 1'b1;
        step();
        check_outs("paused", 3'd1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        miss(1'b1, 1'b1);
        check("paused.frozen", 32'(bus.state), 32'd1);
        bus.pause_btn = 1'b0;
        step();
        bus.pause_btn = 1'b1;
        step();
        check("resumed.paddle", 32'(bus.paddle_move_en), 32'd1);
        tick();
        check("resumed.one_tick", 32'(bus.state), 32'd1);
        tick();
        check_outs("resumed.play", 3'd2, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        bus.pause_btn = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
